// File: rtl/spill_buffer_flushable.sv
// spill_buffer_flushable
//   Multi-entry spill buffer for valid/ready streams. Both ready_o and valid_o
//   come from registered state, so the upstream and downstream handshakes are
//   fully decoupled. The only combinational input in the buffered mode is
//   flush_i, which gates both handshakes. With Bypass=1 the block is plain
//   wires.
//
// Ports
//   clk_i    : clock, rising edge
//   rst_i    : asynchronous reset, active high
//   clr_i    : synchronous clear (empties at next edge, does not gate handshakes)
//   flush_i  : gates both handshakes this cycle, empties at next edge
//   valid_i  / ready_o / data_i  : upstream handshake and payload
//   valid_o  / ready_i / data_o  : downstream handshake and head payload
//   usage_o  : number of stored entries (0..Depth), registered
module spill_buffer_flushable #(
  parameter type         T          = logic,
  parameter int unsigned Depth      = 2,
  parameter bit          Bypass     = 1'b0,
  parameter int unsigned UsageWidth = $clog2(Depth + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clr_i,
  input  logic                  flush_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  T                      data_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output T                      data_o,
  output logic [UsageWidth-1:0] usage_o
);

  if (Bypass) begin : g_bypass
    // Transparent: clocking, clear and flush have no meaning here.
    logic unused_ctrl;
    assign unused_ctrl = ^{clk_i, rst_i, clr_i, flush_i};

    assign valid_o = valid_i;
    assign ready_o = ready_i;
    assign data_o  = data_i;
    assign usage_o = '0;
  end else begin : g_buf
    // Depth=1 still gets a 1-bit pointer; the wrap logic then keeps it at 0.
    localparam int unsigned           PtrW    = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [PtrW-1:0]       LastPtr = PtrW'(Depth - 1);
    localparam logic [UsageWidth-1:0] FullCnt = UsageWidth'(Depth);

    T                      mem [Depth];
    logic [PtrW-1:0]       rd_ptr, wr_ptr;
    logic [UsageWidth-1:0] count;
    logic                  push, pop, drop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == LastPtr) ? '0 : p + 1'b1;
    endfunction

    assign ready_o = (count != FullCnt) && !flush_i;
    assign valid_o = (count != '0) && !flush_i;
    assign data_o  = mem[rd_ptr];
    assign usage_o = count;

    assign push = valid_i && ready_o;
    assign pop  = valid_o && ready_i;
    // Clear/flush win over any handshake seen in the same cycle; note clr_i
    // does not drop ready_o/valid_o, so such a transfer is simply lost.
    assign drop = flush_i || clr_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else if (drop) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= ptr_inc(wr_ptr);
        if (pop)  rd_ptr <= ptr_inc(rd_ptr);
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end

    // Storage is only reset, never cleared by clr/flush; stale entries are
    // unreachable because count returns to zero.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        for (int i = 0; i < Depth; i++) mem[i] <= '0;
      end else if (push && !drop) begin
        mem[wr_ptr] <= data_i;
      end
    end
  end

endmodule

// File: tb/tb_spill_buffer_flushable.sv
module tb_spill_buffer_flushable;

  typedef logic [7:0] byte_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Depth=2 instance
  logic v2 = 0, r2 = 0, f2 = 0, c2 = 0; byte_t d2 = '0;
  logic vo2, ro2; byte_t do2; logic [1:0] us2;
  // Depth=3 instance
  logic v3 = 0, r3 = 0, f3 = 0, c3 = 0; byte_t d3 = '0;
  logic vo3, ro3; byte_t do3; logic [1:0] us3;
  // Bypass instance
  logic vb = 0, rb = 0, fb = 0, cb = 0; byte_t db = '0;
  logic vob, rob; byte_t dob; logic [1:0] usb;

  spill_buffer_flushable #(.T(byte_t), .Depth(2)) u2 (
    .clk_i(clk), .rst_i(rst), .clr_i(c2), .flush_i(f2), .valid_i(v2), .ready_o(ro2),
    .data_i(d2), .valid_o(vo2), .ready_i(r2), .data_o(do2), .usage_o(us2));
  spill_buffer_flushable #(.T(byte_t), .Depth(3)) u3 (
    .clk_i(clk), .rst_i(rst), .clr_i(c3), .flush_i(f3), .valid_i(v3), .ready_o(ro3),
    .data_i(d3), .valid_o(vo3), .ready_i(r3), .data_o(do3), .usage_o(us3));
  spill_buffer_flushable #(.T(byte_t), .Depth(2), .Bypass(1'b1)) ub (
    .clk_i(clk), .rst_i(rst), .clr_i(cb), .flush_i(fb), .valid_i(vb), .ready_o(rob),
    .data_i(db), .valid_o(vob), .ready_i(rb), .data_o(dob), .usage_o(usb));

  int checks = 0;
  int errors = 0;

  // Reference model: plain FIFO of accepted payloads for the active instance.
  byte_t q[$];
  int    dep = 2;
  // Previous-cycle observation for the hold-until-ready protocol rule.
  logic  prev_vld = 0, prev_rdy = 0, prev_abort = 0;
  byte_t prev_dat = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic v, input byte_t d, input logic r,
                       input logic fl, input logic cl);
    if (sel == 2) begin v2 = v; d2 = d; r2 = r; f2 = fl; c2 = cl; end
    else          begin v3 = v; d3 = d; r3 = r; f3 = fl; c3 = cl; end
  endtask

  task automatic sample(input int sel, output logic ov, output logic orr,
                        output byte_t od, output logic [1:0] ou);
    if (sel == 2) begin ov = vo2; orr = ro2; od = do2; ou = us2; end
    else          begin ov = vo3; orr = ro3; od = do3; ou = us3; end
  endtask

  // One clock cycle on the selected instance, checked against the model.
  task automatic step(input int sel, input logic v, input byte_t d, input logic r,
                      input logic fl, input logic cl, input string tag);
    logic ov, orr, ov2, orr2; byte_t od, od2; logic [1:0] ou, ou2;
    logic exp_v, exp_r;
    drive(sel, v, d, r, fl, cl);
    @(negedge clk);
    sample(sel, ov, orr, od, ou);
    exp_v = (q.size() > 0) && !fl;
    exp_r = (q.size() < dep) && !fl;
    chk({tag, ".valid_o"}, ov, exp_v);
    chk({tag, ".ready_o"}, orr, exp_r);
    chk({tag, ".usage_o"}, ou, q.size());
    if (q.size() > 0) chk({tag, ".data_o"}, od, q[0]);
    if (prev_vld && !prev_rdy && !prev_abort && !fl) begin
      chk({tag, ".hold_valid"}, ov, 1'b1);
      chk({tag, ".hold_data"}, od, prev_dat);
    end
    // ready_o/valid_o must not follow valid_i/ready_i within the cycle.
    drive(sel, !v, d, !r, fl, cl);
    #1;
    sample(sel, ov2, orr2, od2, ou2);
    chk({tag, ".ready_o_indep"}, orr2, exp_r);
    chk({tag, ".valid_o_indep"}, ov2, exp_v);
    drive(sel, v, d, r, fl, cl);
    #1;
    prev_vld = ov; prev_rdy = r; prev_dat = od; prev_abort = fl || cl;
    if (fl || cl) q.delete();
    else begin
      if (exp_v && r) void'(q.pop_front());
      if (exp_r && v) q.push_back(d);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    drive(2, 0, '0, 0, 0, 0);
    drive(3, 0, '0, 0, 0, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    #2;
    chk({tag, ".u2.valid_o"}, vo2, 1'b0);
    chk({tag, ".u2.ready_o"}, ro2, 1'b1);
    chk({tag, ".u2.usage_o"}, us2, 0);
    chk({tag, ".u2.data_o"},  do2, 0);
    chk({tag, ".u3.valid_o"}, vo3, 1'b0);
    chk({tag, ".u3.ready_o"}, ro3, 1'b1);
    chk({tag, ".u3.usage_o"}, us3, 0);
    chk({tag, ".u3.data_o"},  do3, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    prev_vld = 0;
  endtask

  initial begin
    #1;
    // Reset
    do_reset("reset");

    // Fill and drain, Depth=3
    dep = 3;
    step(3, 1, 8'h0A, 0, 0, 0, "fill_a");
    step(3, 1, 8'h0B, 0, 0, 0, "fill_b");
    step(3, 1, 8'h0C, 0, 0, 0, "fill_c");
    step(3, 1, 8'h0D, 0, 0, 0, "full3");
    for (int i = 0; i < 4; i++) step(3, 0, '0, 1, 0, 0, $sformatf("drain%0d", i));

    // Streaming, Depth=2
    do_reset("reset2");
    dep = 2;
    for (int i = 0; i < 100; i++) begin
      step(2, 1, byte_t'(i), 1, 0, 0, $sformatf("stream%0d", i));
      if (i > 0) chk($sformatf("stream%0d.usage1", i), us2, 1);
    end
    step(2, 0, '0, 1, 0, 0, "stream_end");
    step(2, 0, '0, 1, 0, 0, "stream_empty");

    // Full boundary, Depth=2
    step(2, 1, 8'h20, 0, 0, 0, "fb_p0");
    step(2, 1, 8'h21, 0, 0, 0, "fb_p1");
    step(2, 1, 8'h22, 1, 0, 0, "fb_full_pop");
    step(2, 1, 8'h23, 0, 0, 0, "fb_push");
    for (int i = 0; i < 3; i++) step(2, 0, '0, 1, 0, 0, $sformatf("fb_drain%0d", i));

    // Flush with both handshakes requested
    step(2, 1, 8'h31, 0, 0, 0, "fl_p0");
    step(2, 1, 8'h32, 0, 0, 0, "fl_p1");
    step(2, 1, 8'h77, 1, 1, 0, "flush");
    step(2, 1, 8'h05, 0, 0, 0, "fl_push5");
    step(2, 0, '0, 1, 0, 0, "fl_out5");
    step(2, 0, '0, 1, 0, 0, "fl_empty");

    // Clear aborts a pending transfer
    step(2, 1, 8'h41, 0, 0, 0, "clr_p0");
    step(2, 1, 8'h42, 1, 0, 1, "clr");
    step(2, 1, 8'h43, 0, 0, 0, "clr_push");
    step(2, 0, '0, 1, 0, 0, "clr_out");

    // Reset in mid-stream drops everything immediately
    step(2, 1, 8'h51, 0, 0, 0, "mid_p0");
    step(2, 1, 8'h52, 0, 0, 0, "mid_p1");
    do_reset("mid_reset");

    // Random bursts across pointer wrap, Depth=3
    dep = 3;
    for (int b = 0; b < 10; b++) begin
      int len;
      len = $urandom_range(4, 9);
      for (int i = 0; i < len; i++) begin
        step(3, ($urandom % 4) != 0, byte_t'($urandom), ($urandom % 3) != 0,
             ($urandom % 25) == 0, ($urandom % 25) == 0, $sformatf("wrap%0d_%0d", b, i));
      end
    end
    for (int i = 0; i < 4; i++) step(3, 0, '0, 1, 0, 0, $sformatf("wrap_drain%0d", i));

    // Bypass: pure wires, clear/flush ignored
    for (int i = 0; i < 8; i++) begin
      logic ev, er; byte_t ed;
      ev = $urandom % 2; er = $urandom % 2; ed = byte_t'($urandom);
      vb = ev; rb = er; db = ed; cb = $urandom % 2; fb = $urandom % 2;
      #1;
      chk($sformatf("byp%0d.valid_o", i), vob, ev);
      chk($sformatf("byp%0d.ready_o", i), rob, er);
      chk($sformatf("byp%0d.data_o", i), dob, ed);
      chk($sformatf("byp%0d.usage_o", i), usb, 0);
      @(posedge clk); #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
